// File: rtl/axis_mirrors_merge.sv
// ---------------------------------------------------------------------------
// axis_mirrors_merge
//
// Packet-level AXI-Stream fan-in. NUM input streams are merged into one output
// stream by round-robin arbitration. Once a source is granted, it keeps the
// output until the handshake of its tlast beat. The granted source index is
// exported so that downstream logic can route or tag each packet.
//
// Optional feature (compile-time macro AXIS_MIRRORS_MERGE_OREG_EN):
//   defined     - a full-throughput output register stage is inserted
//                 (1 cycle data latency).
//   not defined - the output is driven combinationally from the granted input
//                 (0 cycle data latency).
//
// Ports:
//   clock         sole clock
//   rst           asynchronous, active-high reset
//   i_in_tvalid   [NUM]        per-input tvalid
//   o_in_tready   [NUM]        per-input tready
//   i_in_tdata    [NUM*DSIZE]  per-input tdata, input k at [k*DSIZE +: DSIZE]
//   i_in_tlast    [NUM]        per-input tlast
//   o_out_tvalid               merged output tvalid
//   i_out_tready               merged output tready
//   o_out_tdata   [DSIZE]      merged output tdata
//   o_out_tlast                merged output tlast
//   o_src_index   [IW]         index of the currently granted input
//   o_busy                     high while a packet is locked
// ---------------------------------------------------------------------------
module axis_mirrors_merge #(
  parameter  int NUM   = 8,
  parameter  int DSIZE = 8,
  localparam int IW    = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM-1:0]       i_in_tvalid,
  output logic [NUM-1:0]       o_in_tready,
  input  logic [NUM*DSIZE-1:0] i_in_tdata,
  input  logic [NUM-1:0]       i_in_tlast,
  output logic                 o_out_tvalid,
  input  logic                 i_out_tready,
  output logic [DSIZE-1:0]     o_out_tdata,
  output logic                 o_out_tlast,
  output logic [IW-1:0]        o_src_index,
  output logic                 o_busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_grant;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic            w_lock;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic [DSIZE-1:0] w_sel_data;
  logic            w_src_ready;
  logic            w_accept;
  logic [IW-1:0]   w_next_ptr;

  assign w_lock = (r_state == ST_LOCK);

  // Round-robin search: first valid input at or above r_rr_ptr, wrapping
  // NUM-1 -> 0. The sum is one bit wider so the wrap works for any NUM.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [IW:0] v_sum;
    w_found = 1'b0;
    w_pick  = '0;
    v_sum   = '0;
    for (int i = 0; i < NUM; i++) begin
      v_sum = {1'b0, r_rr_ptr} + (IW+1)'(i);
      if (v_sum >= (IW+1)'(NUM)) begin
        v_sum = v_sum - (IW+1)'(NUM);
      end
      if (!w_found && i_in_tvalid[v_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = v_sum[IW-1:0];
      end
    end
  end

  // Granted-input mux, written with constant selects only.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM; i++) begin
      if (r_grant == IW'(i)) begin
        w_sel_valid = i_in_tvalid[i];
        w_sel_last  = i_in_tlast[i];
        w_sel_data  = i_in_tdata[i*DSIZE +: DSIZE];
      end
    end
  end

  // Only the granted input sees a ready, and only while locked.
  always_comb begin
    o_in_tready = '0;
    for (int i = 0; i < NUM; i++) begin
      o_in_tready[i] = w_lock && (r_grant == IW'(i)) && w_src_ready;
    end
  end

  assign w_accept   = w_lock && w_sel_valid && w_src_ready;
  assign w_next_ptr = (r_grant == IW'(NUM-1)) ? '0 : r_grant + 1'b1;

`ifdef AXIS_MIRRORS_MERGE_OREG_EN
  logic             r_out_valid;
  logic [DSIZE-1:0] r_out_data;
  logic             r_out_last;

  // The register accepts a new beat whenever it is empty or draining this
  // cycle, which keeps a full 1 beat/cycle through the stage.
  assign w_src_ready = !r_out_valid || i_out_tready;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
    end else if (i_out_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_tvalid = r_out_valid;
  assign o_out_tdata  = r_out_data;
  assign o_out_tlast  = r_out_last;
`else
  assign w_src_ready  = i_out_tready;
  assign o_out_tvalid = w_lock && w_sel_valid;
  assign o_out_tdata  = w_lock ? w_sel_data : '0;
  assign o_out_tlast  = w_lock && w_sel_last;
`endif

  // Arbitration FSM. The lock releases only on the tlast handshake; a source
  // dropping tvalid mid-packet keeps the lock.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_accept && w_sel_last) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = w_lock;
  assign o_src_index = r_grant;

endmodule

// File: tb/tb_axis_mirrors_merge.sv
// ---------------------------------------------------------------------------
// tb_axis_mirrors_merge
//
// Randomized bench for axis_mirrors_merge (NUM=4, DSIZE=8, default build
// without the output register). Each source holds a queue of random packets
// (1..4 beats) and presents them with random tvalid gaps, and the output
// tready is random. The reference model tracks lock ownership and the
// round-robin pointer from the arbitration rules and scores every output beat
// against the granted source's own packet queue. A reset is pulsed mid-packet.
// ---------------------------------------------------------------------------
module tb_axis_mirrors_merge;

  localparam int NUM   = 4;
  localparam int DSIZE = 8;
  localparam int IW    = 2;
  localparam int N_CYC = 3000;

  logic                 clock = 1'b0;
  logic                 rst;
  logic [NUM-1:0]       i_in_tvalid;
  logic [NUM-1:0]       o_in_tready;
  logic [NUM*DSIZE-1:0] i_in_tdata;
  logic [NUM-1:0]       i_in_tlast;
  logic                 o_out_tvalid;
  logic                 i_out_tready;
  logic [DSIZE-1:0]     o_out_tdata;
  logic                 o_out_tlast;
  logic [IW-1:0]        o_src_index;
  logic                 o_busy;

  always #5 clock = ~clock;

  axis_mirrors_merge #(.NUM(NUM), .DSIZE(DSIZE)) dut (
    .clock        (clock),
    .rst          (rst),
    .i_in_tvalid  (i_in_tvalid),
    .o_in_tready  (o_in_tready),
    .i_in_tdata   (i_in_tdata),
    .i_in_tlast   (i_in_tlast),
    .o_out_tvalid (o_out_tvalid),
    .i_out_tready (i_out_tready),
    .o_out_tdata  (o_out_tdata),
    .o_out_tlast  (o_out_tlast),
    .o_src_index  (o_src_index),
    .o_busy       (o_busy)
  );

  typedef struct packed {
    logic [DSIZE-1:0] d;
    logic             l;
  } beat_t;

  beat_t q_src [NUM][$];   // pending beats per source, front = presented beat

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the output and where the next search starts.
  bit m_busy;
  int m_grant;
  int m_ptr;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic refill();
    for (int i = 0; i < NUM; i++) begin
      if (q_src[i].size() == 0 && $urandom_range(0, 3) != 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          beat_t bt;
          bt.d = DSIZE'($urandom);
          bt.l = (b == len - 1);
          q_src[i].push_back(bt);
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      if (q_src[i].size() > 0) begin
        i_in_tvalid[i]               = ($urandom_range(0, 9) < 7);
        i_in_tdata[i*DSIZE +: DSIZE] = q_src[i][0].d;
        i_in_tlast[i]                = q_src[i][0].l;
      end else begin
        i_in_tvalid[i]               = 1'b0;
        i_in_tdata[i*DSIZE +: DSIZE] = DSIZE'($urandom);
        i_in_tlast[i]                = 1'($urandom);
      end
    end
    i_out_tready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic flush();
    for (int i = 0; i < NUM; i++) q_src[i].delete();
    i_in_tvalid = '0;
    i_in_tlast  = '0;
    m_busy  = 1'b0;
    m_grant = 0;
    m_ptr   = 0;
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, "_busy"},      o_busy,       0);
    check({where, "_src_index"}, o_src_index,  0);
    check({where, "_out_tvalid"},o_out_tvalid, 0);
    check({where, "_out_tdata"}, o_out_tdata,  0);
    check({where, "_out_tlast"}, o_out_tlast,  0);
    check({where, "_in_tready"}, o_in_tready,  0);
  endtask

  initial begin
    bit rst_done = 0;

    // Reset with all inputs asserting valid: nothing may be granted or ready.
    rst          = 1'b1;
    i_in_tvalid  = '1;
    i_in_tlast   = '1;
    i_in_tdata   = '1;
    i_out_tready = 1'b1;
    #22;
    check_reset_outputs("reset");
    @(negedge clock);
    flush();
    rst = 1'b0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      logic [NUM-1:0] exp_rdy;
      bit             exp_ov;
      int             pop_src;

      @(negedge clock);

      check("busy", o_busy, m_busy);
      if (m_busy) check("src_index", o_src_index, m_grant);

      exp_rdy = '0;
      if (m_busy) exp_rdy[m_grant] = i_out_tready;
      check("in_tready", o_in_tready, exp_rdy);

      exp_ov = m_busy && i_in_tvalid[m_grant];
      check("out_tvalid", o_out_tvalid, exp_ov);
      pop_src = -1;
      if (exp_ov) begin
        check("out_tdata", o_out_tdata, q_src[m_grant][0].d);
        check("out_tlast", o_out_tlast, q_src[m_grant][0].l);
        if (i_out_tready) pop_src = m_grant;
      end

      // Advance the model to what the upcoming edge must do.
      if (!m_busy) begin
        for (int k = 0; k < NUM; k++) begin
          int idx;
          idx = (m_ptr + k) % NUM;
          if (!m_busy && i_in_tvalid[idx]) begin
            m_busy  = 1'b1;
            m_grant = idx;
          end
        end
      end else if (pop_src >= 0 && q_src[m_grant][0].l) begin
        m_busy = 1'b0;
        m_ptr  = (m_grant + 1) % NUM;
      end

      @(posedge clock);
      #1;
      if (pop_src >= 0) void'(q_src[pop_src].pop_front());

      // Asynchronous reset in the middle of a locked packet.
      if (!rst_done && cyc >= N_CYC/2 && m_busy) begin
        rst_done = 1;
        i_in_tvalid  = '1;
        i_out_tready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clock);
        flush();
        rst = 1'b0;
        continue;
      end

      refill();
      drive();
    end

    check("midrst_reached", rst_done, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
